hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline hazard detection unit. It tracks destination registers through NUM_STAGES post-ID stages and produces per-operand forwarding selects by youngest-match priority. It also detects load-use and multi-cycle-unit (mul/div) dependencies and drives stall, bubble and flush controls. It sits beside the ID stage and is fed by decode, the pipeline advance strobe and branch/exception/ret redirect.

---
 rtl/hazard_scoreboard_pkg.sv | 37 +++
 rtl/hazard_scoreboard_if.sv | 45 ++++
 rtl/hazard_scoreboard_mc_tracker.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard: pipeline stage entry,
// select-width computation and youngest-match priority.
package hazard_pkg;

  localparam int MAX_STAGES = 6;
  localparam int MAX_REG_AW = 8;
  localparam int MC_CNT_W   = 5;
  localparam int FWD_RF     = 0;

  // rd is held at the widest supported address width; narrower configs zero-extend
  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } stage_entry_t;

  function automatic int sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // bit i of m is stage i+1; the smallest set stage wins, FWD_RF if none
  function automatic int youngest_match(input logic [MAX_STAGES-1:0] m);
    int r;
    r = FWD_RF;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (m[i]) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic stage_match(input stage_entry_t e, input logic use_rs,
                                       input logic [MAX_REG_AW-1:0] rs);
    return use_rs && (rs != '0) && e.valid && e.reg_write && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3
);
  localparam int SEL_W = sel_w(NUM_STAGES);

  logic              advance;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_is_load;
  logic              id_is_mc;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic              flush_if;
  logic              flush_id;
  logic              mc_busy;
  logic              mc_wb;

  modport master (
    output advance, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_is_load, id_is_mc,
    input  fwd_sel_a, fwd_sel_b, stall_if, stall_id, bubble_ex, flush_if,
           flush_id, mc_busy, mc_wb
  );

  modport slave (
    input  advance, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_is_load, id_is_mc,
    output fwd_sel_a, fwd_sel_b, stall_if, stall_id, bubble_ex, flush_if,
           flush_id, mc_busy, mc_wb
  );

endinterface

// File: rtl/hazard_scoreboard_mc_tracker.sv
// Multi-cycle unit result tracker: latency counter, pending destination and
// the RAW/WAW/structural dependency check against the ID instruction.
module hazard_mc_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_mc,
  output logic              mc_hazard,
  output logic              mc_busy,
  output logic              mc_wb
);

  logic [MC_CNT_W-1:0] cnt;
  logic [REG_AW-1:0]   mc_rd;
  logic                mc_pending;
  logic                raw_hit;
  logic                waw_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      mc_rd      <= '0;
      mc_pending <= 1'b0;
    end else if (issue) begin
      cnt        <= MC_CNT_W'(MC_LATENCY - 1);
      mc_rd      <= id_rd;
      mc_pending <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (mc_wb) mc_pending <= 1'b0;
    end
  end

  // no bypass from the multi-cycle unit: consumers wait until write-back has happened
  assign raw_hit   = (id_use_rs1 && (id_rs1 != '0) && (id_rs1 == mc_rd)) ||
                     (id_use_rs2 && (id_rs2 != '0) && (id_rs2 == mc_rd));
  assign waw_hit   = id_reg_write && (id_rd == mc_rd);
  assign mc_hazard = mc_pending && id_valid && (raw_hit || waw_hit || id_is_mc);
  assign mc_busy   = mc_pending;
  assign mc_wb     = mc_pending && (cnt == MC_CNT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks destinations through the post-ID stages,
// picks forwarding sources and drives stall/bubble/flush controls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 2,
  parameter int MC_LATENCY = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_STAGES);

  stage_entry_t          stg [1:NUM_STAGES];
  stage_entry_t          id_entry;
  logic [MAX_STAGES-1:0] match_a;
  logic [MAX_STAGES-1:0] match_b;
  int                    sel_a;
  int                    sel_b;
  logic                  load_use;
  logic                  mc_hazard;
  logic                  hazard;
  logic                  flush_eff;
  logic                  stall;
  logic                  bubble;
  logic                  mc_issue;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      match_a[k-1] = stage_match(stg[k], bus.id_use_rs1, MAX_REG_AW'(bus.id_rs1));
      match_b[k-1] = stage_match(stg[k], bus.id_use_rs2, MAX_REG_AW'(bus.id_rs2));
    end
  end

  assign sel_a = youngest_match(match_a);
  assign sel_b = youngest_match(match_b);

  always_comb begin
    load_use = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if ((k < LOAD_READY) && stg[k].is_load && ((sel_a == k) || (sel_b == k)))
        load_use = 1'b1;
    end
  end

  hazard_mc_tracker #(
    .REG_AW     (REG_AW),
    .MC_LATENCY (MC_LATENCY)
  ) u_mc (
    .clk          (clk),
    .reset        (reset),
    .issue        (mc_issue),
    .id_valid     (bus.id_valid),
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .id_use_rs1   (bus.id_use_rs1),
    .id_use_rs2   (bus.id_use_rs2),
    .id_rd        (bus.id_rd),
    .id_reg_write (bus.id_reg_write),
    .id_is_mc     (bus.id_is_mc),
    .mc_hazard    (mc_hazard),
    .mc_busy      (bus.mc_busy),
    .mc_wb        (bus.mc_wb)
  );

  // redirect wins over any stall; a stalled ID instruction is simply discarded
  assign flush_eff = bus.flush && !reset;
  assign hazard    = bus.id_valid && (load_use || mc_hazard);
  assign stall     = hazard && !flush_eff;
  assign bubble    = stall || flush_eff;
  assign mc_issue  = bus.advance && !bubble && bus.id_valid && bus.id_is_mc;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = bus.id_valid;
    id_entry.rd        = MAX_REG_AW'(bus.id_rd);
    id_entry.reg_write = bus.id_reg_write && !bus.id_is_mc;
    id_entry.is_load   = bus.id_is_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= NUM_STAGES; k++) stg[k] <= '0;
    end else if (bus.advance) begin
      for (int k = NUM_STAGES; k >= 2; k--) stg[k] <= stg[k-1];
      stg[1] <= bubble ? stage_entry_t'('0) : id_entry;
    end
  end

  assign bus.fwd_sel_a = SEL_W'(sel_a);
  assign bus.fwd_sel_b = SEL_W'(sel_b);
  assign bus.stall_if  = stall;
  assign bus.stall_id  = stall;
  assign bus.bubble_ex = bubble;
  assign bus.flush_if  = flush_eff;
  assign bus.flush_id  = flush_eff;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, multi-cycle,
// flush priority, no-advance hold and asynchronous reset mid-operation.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  hazard_scoreboard_if #(.REG_AW(5), .NUM_STAGES(3)) bus ();

  hazard_scoreboard #(
    .REG_AW     (5),
    .NUM_STAGES (3),
    .LOAD_READY (2),
    .MC_LATENCY (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic ld, input logic mc);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_use_rs1   = u1;
    bus.id_rs2       = rs2;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_is_load   = ld;
    bus.id_is_mc     = mc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int exp_wb [5];
    int exp_busy [5];
    exp_wb   = '{0, 1, 0, 0, 0};
    exp_busy = '{1, 1, 0, 0, 0};

    reset       = 1'b1;
    bus.advance = 1'b0;
    bus.flush   = 1'b0;
    drive_id(1, 5, 1, 5, 1, 0, 0, 0, 0);
    #2;
    chk("reset_fwd_a", bus.fwd_sel_a, 0);
    chk("reset_stall", bus.stall_id, 0);
    chk("reset_busy", bus.mc_busy, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();

    // forwarding: two writers of x5, the youngest wins
    bus.advance = 1'b1;
    drive_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    tick();
    drive_id(1, 5, 1, 5, 0, 0, 1, 0, 0);
    settle();
    chk("fwd_a_s1", bus.fwd_sel_a, 1);
    chk("fwd_b_unused", bus.fwd_sel_b, 0);
    chk("fwd_no_stall", bus.stall_id, 0);
    tick();
    drive_id(1, 0, 1, 5, 1, 0, 0, 0, 0);
    settle();
    chk("fwd_x0", bus.fwd_sel_a, 0);
    chk("fwd_b_s2", bus.fwd_sel_b, 2);
    chk("x0_no_stall", bus.stall_id, 0);

    // load-use on rs2
    drive_id(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive_id(1, 0, 0, 7, 1, 3, 1, 0, 0);
    settle();
    chk("lu_stall_id", bus.stall_id, 1);
    chk("lu_stall_if", bus.stall_if, 1);
    chk("lu_bubble", bus.bubble_ex, 1);
    tick();
    chk("lu_fwd_b", bus.fwd_sel_b, 2);
    chk("lu_release", bus.stall_id, 0);
    chk("lu_no_bubble", bus.bubble_ex, 0);

    // flush during a load-use stall
    drive_id(1, 0, 0, 0, 0, 8, 1, 1, 0);
    tick();
    drive_id(1, 8, 1, 0, 0, 10, 1, 0, 0);
    bus.flush = 1'b1;
    settle();
    chk("fl_stall_id", bus.stall_id, 0);
    chk("fl_stall_if", bus.stall_if, 0);
    chk("fl_bubble", bus.bubble_ex, 1);
    chk("fl_flush_id", bus.flush_id, 1);
    chk("fl_flush_if", bus.flush_if, 1);
    tick();
    bus.flush = 1'b0;
    drive_id(1, 10, 1, 8, 1, 0, 0, 0, 0);
    settle();
    chk("fl_discarded", bus.fwd_sel_a, 0);
    chk("fl_fwd_b", bus.fwd_sel_b, 2);
    chk("fl_flush_off", bus.flush_id, 0);

    // MUL x9 then a consumer of x9
    drive_id(1, 0, 0, 0, 0, 9, 1, 0, 1);
    settle();
    chk("mc_idle", bus.mc_busy, 0);
    tick();
    drive_id(1, 9, 1, 0, 0, 17, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mc_stall_%0d", i), bus.stall_id, 1);
      chk($sformatf("mc_wb_%0d", i), bus.mc_wb, (i == 2) ? 1 : 0);
      chk($sformatf("mc_nofwd_%0d", i), bus.fwd_sel_a, 0);
      tick();
    end
    settle();
    chk("mc_release", bus.stall_id, 0);
    chk("mc_done", bus.mc_busy, 0);
    chk("mc_rf", bus.fwd_sel_a, 0);

    // second MUL and dependency variants while pending
    drive_id(1, 0, 0, 0, 0, 11, 1, 0, 1);
    tick();
    bus.advance = 1'b0;
    drive_id(1, 0, 0, 0, 0, 12, 1, 0, 1);
    settle();
    chk("mc_struct", bus.stall_id, 1);
    drive_id(1, 0, 0, 0, 0, 11, 1, 0, 0);
    settle();
    chk("mc_waw", bus.stall_id, 1);
    drive_id(1, 5, 1, 0, 0, 13, 1, 0, 0);
    settle();
    chk("mc_indep", bus.stall_id, 0);
    drive_id(1, 11, 1, 0, 0, 13, 1, 0, 0);
    settle();
    chk("mc_raw", bus.stall_id, 1);

    // load-use held with no advance while the MC counter keeps running
    drive_id(1, 0, 0, 0, 0, 14, 1, 1, 0);
    bus.advance = 1'b1;
    tick();
    bus.advance = 1'b0;
    drive_id(1, 14, 1, 0, 0, 16, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("hold_stall_%0d", i), bus.stall_id, 1);
      chk($sformatf("hold_fwd_%0d", i), bus.fwd_sel_a, 1);
      chk($sformatf("hold_wb_%0d", i), bus.mc_wb, exp_wb[i]);
      chk($sformatf("hold_busy_%0d", i), bus.mc_busy, exp_busy[i]);
      tick();
    end
    bus.advance = 1'b1;
    tick();
    chk("hold_release", bus.stall_id, 0);
    chk("hold_fwd_s2", bus.fwd_sel_a, 2);

    // reset mid-MC with counter at 2
    tick();
    drive_id(1, 0, 0, 0, 0, 15, 1, 0, 1);
    tick();
    bus.advance = 1'b0;
    drive_id(1, 16, 1, 15, 1, 0, 0, 0, 0);
    tick();
    chk("rst_pre_fwd", bus.fwd_sel_a, 2);
    chk("rst_pre_stall", bus.stall_id, 1);
    chk("rst_pre_busy", bus.mc_busy, 1);
    chk("rst_pre_wb", bus.mc_wb, 0);
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", bus.mc_busy, 0);
    chk("rst_stall", bus.stall_id, 0);
    chk("rst_bubble", bus.bubble_ex, 0);
    chk("rst_fwd_a", bus.fwd_sel_a, 0);
    chk("rst_fwd_b", bus.fwd_sel_b, 0);
    tick();
    chk("rst_no_wb", bus.mc_wb, 0);
    chk("rst_busy_hold", bus.mc_busy, 0);
    #1 reset = 1'b0;
    tick();
    chk("post_fwd_a", bus.fwd_sel_a, 0);
    chk("post_fwd_b", bus.fwd_sel_b, 0);
    chk("post_stall", bus.stall_id, 0);
    chk("post_busy", bus.mc_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
